// File: rtl/scpu_pkg.sv
// scpu_pkg
// Shared constants for the small CPU front end: the main opcode field values
// seen by the control decoder, the canonical NOP (addi x0,x0,0) and the
// encoding of the fetch state register.
package scpu_pkg;

    // Major opcodes presented on id_opcode to the main control decoder
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_S  = 7'b0100011;
    localparam logic [6:0] OP_SB = 7'b1100011;

    // addi x0,x0,0 -- what decode sees whenever nothing valid is held
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Fetch state encoding {BOOT, FETCH, WAIT, HOLD}
    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t ST_BOOT  = 2'd0;
    localparam fetch_state_t ST_FETCH = 2'd1;
    localparam fetch_state_t ST_WAIT  = 2'd2;
    localparam fetch_state_t ST_HOLD  = 2'd3;

endpackage

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen
// Program counter for the fetch stage: holds pc, advances it by 4 when decode
// consumes an instruction, and loads a word-aligned redirect target from
// execute. Flags a misaligned redirect target with a one-cycle pulse.
//
// Ports:
//   clk, rst_n      clock / async active-low reset
//   advance         decode consumed the held instruction, step pc by 4
//   redirect_valid  load redirect target (wins over advance)
//   redirect_pc     redirect target, low two bits dropped
//   pc              current fetch pc
//   misalign_err    one-cycle pulse, redirect target had nonzero low bits
module fetch_pc_gen
    import scpu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            advance,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc,
    output logic            misalign_err
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    // Redirect beats sequential advance; the increment wraps at 2^XLEN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= RESET_PC;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (redirect_valid) begin
                pc <= {redirect_pc[XLEN-1:2], 2'b00};
            end else if (advance) begin
                pc <= pc + PC_STEP;
            end
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch
// Fetch stage in front of the main opcode decoder. Issues one outstanding
// request at a time to instruction memory (req/gnt/rvalid), holds the returned
// word for decode under valid/ready, and accepts redirects from execute,
// discarding any fetch that was already in flight.
//
// Ports:
//   clk, rst_n                      clock / async active-low reset
//   imem_req, imem_addr             request and word-aligned address
//   imem_gnt, imem_rvalid, imem_rdata  memory accept, response valid, data
//   redirect_valid, redirect_pc     branch/jump from execute
//   id_valid, id_ready              handshake to decode
//   id_pc, id_instr, id_opcode      instruction (and its opcode) to decode
//   misalign_err                    pulse on misaligned redirect target
module instr_fetch #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0]     NOP_INSTR = scpu_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_instr,
    output logic [6:0]      id_opcode,
    output logic            misalign_err
);

    import scpu_pkg::*;

    fetch_state_t    state;
    logic            kill;
    logic            advance;
    logic [XLEN-1:0] pc;

    // Only a genuine consume steps the pc; a redirect in the same cycle wins.
    assign advance = (state == ST_HOLD) && id_ready && !redirect_valid;

    fetch_pc_gen #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk            (clk),
        .rst_n          (rst_n),
        .advance        (advance),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc             (pc),
        .misalign_err   (misalign_err)
    );

    assign imem_req  = (state == ST_FETCH);
    assign imem_addr = pc;
    assign id_opcode = id_instr[6:0];

    // kill marks an accepted request whose response must be thrown away
    // because a redirect arrived after the memory granted it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_BOOT;
            kill     <= 1'b0;
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
            id_pc    <= RESET_PC;
        end else begin
            case (state)
                ST_BOOT: begin
                    state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (imem_gnt) begin
                        kill  <= redirect_valid;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (kill || redirect_valid) begin
                            kill  <= 1'b0;
                            state <= ST_FETCH;
                        end else begin
                            id_instr <= imem_rdata;
                            id_pc    <= pc;
                            id_valid <= 1'b1;
                            state    <= ST_HOLD;
                        end
                    end else if (redirect_valid) begin
                        kill <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (redirect_valid || id_ready) begin
                        id_valid <= 1'b0;
                        id_instr <= NOP_INSTR;
                        state    <= ST_FETCH;
                    end
                end
                default: begin
                    state <= ST_BOOT;
                end
            endcase
        end
    end

endmodule
